pc_fetch_unit: RTL

- Consumes the redirect request (pc_src, target_address) produced by the next-PC logic and owns the architectural fetch PC.
- Issues instruction-memory reads and presents each fetched instruction to decode over a valid/ready handshake.
- Supplies pc_plus4 back to the next-PC logic as its pc operand.
- Sits between instruction memory and decode, closing the PC loop.

---
 rtl/pc_fetch_unit.sv | 71 +++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the fetch PC, issues imem reads and hands instructions to decode
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] target_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4
);
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pending_target;
  logic [31:0] tgt;
  assign tgt       = {target_address[31:2], 2'b00};
  assign imem_req  = !reset && state != HOLD;
  assign imem_addr = fetch_pc;
  assign pc_plus4  = instr_pc + 32'd4;
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      fetch_pc       <= {RESET_PC[31:2], 2'b00};
      pending_target <= '0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
    end else begin
      case (state)
        FETCH:
          if (imem_ack) begin
            if (pc_src) fetch_pc <= tgt;
            else begin
              instr       <= imem_rdata;
              instr_pc    <= fetch_pc;
              instr_valid <= 1'b1;
              fetch_pc    <= fetch_pc + 32'd4;
              state       <= HOLD;
            end
          end else if (pc_src) begin
            pending_target <= tgt;
            state          <= DRAIN;
          end
        // the in-flight read must complete before the redirect takes effect
        DRAIN:
          if (imem_ack) begin
            fetch_pc <= pc_src ? tgt : pending_target;
            state    <= FETCH;
          end else if (pc_src) pending_target <= tgt;
        HOLD:
          if (pc_src) begin
            instr_valid <= 1'b0;
            fetch_pc    <= tgt;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
